// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one 8N2 UART transmitter among N byte sources.
// Optional channel tag byte ahead of each message: define UART_ARB_TAG_EN.
module uart_tx_arbiter #(
  parameter int unsigned N        = 2,
  parameter int unsigned TIMEOUT  = 4096,
  parameter logic [7:0]  TAG_BASE = 8'h80
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_last,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     grant,
  output logic             uart_wr,
  output logic [7:0]       uart_dat,
  input  logic             uart_busy,
  output logic             abort
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned SW = 16;
  localparam logic [SW-1:0] STALL_MAX = '1;
  localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT);

  // Tags are TAG_BASE|owner, so the owner field of TAG_BASE must be clear for distinct tags.
  if (N < 2 || N > 8 || TIMEOUT > 65535 || TAG_BASE[OW-1:0] != '0) begin : g_bad_param
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t          state;
  logic            guard;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   rr_last;
  logic [SW-1:0]   stall_cnt;

  logic            send_ok;
  logic [7:0]      req_byte [N];
  logic [7:0]      own_byte;
  logic            own_valid;
  logic            own_last;
  logic            accept;
  logic [SW-1:0]   stall_nxt;
  logic            stall_expire;
  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic [N-1:0]    win_oh;
  int unsigned     cand;
  logic [OW-1:0]   cand_idx;

  // guard masks the cycle before the UART's busy flag catches up with a write
  assign send_ok = !uart_busy && !guard && !reset;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  assign own_byte     = req_byte[owner];
  assign own_valid    = req_valid[owner];
  assign own_last     = req_last[owner];
  assign accept       = (state == XFER) && send_ok && own_valid;
  assign stall_nxt    = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + SW'(1);
  assign stall_expire = (TIMEOUT != 0) && (stall_nxt >= STALL_LIM);

  // Round-robin pick: first valid requester after rr_last, wrapping modulo N
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(rr_last) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = OW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_oh = '0;
    for (int i = 0; i < N; i++) begin
      win_oh[i] = (win_idx == OW'(i));
    end
  end

  // Write strobe and ready follow send_ok in the same cycle so no byte waits an extra clock
  always_comb begin
    req_ready = '0;
    uart_wr   = 1'b0;
    uart_dat  = '0;
    case (state)
      XFER: begin
        if (send_ok) begin
          req_ready = grant;
          if (own_valid) begin
            uart_wr  = 1'b1;
            uart_dat = own_byte;
          end
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        if (send_ok) begin
          uart_wr  = 1'b1;
          uart_dat = TAG_BASE | 8'(owner);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      guard     <= 1'b1;
      owner     <= '0;
      rr_last   <= OW'(N-1);
      stall_cnt <= '0;
      grant     <= '0;
      abort     <= 1'b0;
    end else begin
      guard <= uart_wr;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (win_found) begin
            owner <= win_idx;
            grant <= win_oh;
`ifdef UART_ARB_TAG_EN
            state <= TAG;
`else
            state <= XFER;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG: begin
          if (send_ok) state <= XFER;
        end
`endif
        XFER: begin
          if (accept) begin
            stall_cnt <= '0;
            if (own_last) begin
              rr_last <= owner;
              grant   <= '0;
              state   <= IDLE;
            end
          end else if (!own_valid) begin
            // Owner went quiet mid-message: revoke once the stall budget is used up
            if (stall_expire) begin
              abort     <= 1'b1;
              grant     <= '0;
              rr_last   <= owner;
              stall_cnt <= '0;
              state     <= IDLE;
            end else begin
              stall_cnt <= stall_nxt;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N=3, TIMEOUT=20, bus-model UART busy for 10 cycles per byte.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic        uart_wr;
  logic [7:0]  uart_dat;
  logic        uart_busy;
  logic        abort;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          log_n = 0;
  int          abort_n = 0;
  int          abort_cyc = 0;
  logic [2:0]  abort_gnt = '0;
  logic [7:0]  log_dat [64];
  logic [2:0]  log_gnt [64];
  int          log_cyc [64];

  logic [8:0]  mem [3][64];
  int          head [3];
  int          tail [3];
  logic [2:0]  acc = '0;
  logic        wr_seen = 1'b0;
  logic        prev_wr = 1'b0;
  int          busy_cnt = 0;

  uart_tx_arbiter #(.N(3), .TIMEOUT(20), .TAG_BASE(8'h80)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant     (grant),
    .uart_wr   (uart_wr),
    .uart_dat  (uart_dat),
    .uart_busy (uart_busy),
    .abort     (abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mem[i][tail[i]] = {l, d};
    tail[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 3; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    clear_src();
    log_n   = 0;
    abort_n = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (log_n < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("wait_log", 32'(log_n >= n), 32'd1);
  endtask

  // Sample on the falling edge: handshakes, UART writes, abort pulses
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      acc     = req_valid & req_ready;
      wr_seen = uart_wr;
      if (uart_wr) begin
        check("wr_while_busy", 32'(uart_busy), 32'd0);
        check("wr_back_to_back", 32'(prev_wr), 32'd0);
        if (log_n < 64) begin
          log_dat[log_n] = uart_dat;
          log_gnt[log_n] = grant;
          log_cyc[log_n] = cyc;
          log_n++;
        end
      end
      prev_wr = uart_wr;
      if (abort) begin
        abort_n++;
        abort_cyc = cyc;
        abort_gnt = grant;
      end
    end
  end

  // Requester sources and UART busy model, updated just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (acc[i] && head[i] < tail[i]) head[i]++;
      end
      if (wr_seen) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      uart_busy = (busy_cnt != 0);
      for (int i = 0; i < 3; i++) begin
        if (head[i] < tail[i]) begin
          req_valid[i]       = 1'b1;
          req_last[i]        = mem[i][head[i]][8];
          req_data[8*i +: 8] = mem[i][head[i]][7:0];
        end else begin
          req_valid[i]       = 1'b0;
          req_last[i]        = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    uart_busy = 1'b0;
    clear_src();

    // 1: single three-byte message from req0
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wr", 32'(uart_wr), 32'd0);
    check("rst_dat", 32'(uart_dat), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    wait_log(3, 200);
    @(negedge clk);
    check("t1_grant_end", 32'(grant), 32'd0);
    check("t1_b0", 32'(log_dat[0]), 32'h41);
    check("t1_b1", 32'(log_dat[1]), 32'h42);
    check("t1_b2", 32'(log_dat[2]), 32'h43);
    for (int m = 0; m < 3; m++) check("t1_gnt", 32'(log_gnt[m]), 32'b001);

    // 2: req0 and req2 together, req0 re-requests immediately
    do_reset();
    push(0, 8'h10, 1'b0);
    push(0, 8'h11, 1'b1);
    push(0, 8'h12, 1'b1);
    push(2, 8'h20, 1'b1);
    wait_log(4, 400);
    repeat (30) @(posedge clk);
    check("t2_count", 32'(log_n), 32'd4);
    check("t2_b0", 32'(log_dat[0]), 32'h10);
    check("t2_b1", 32'(log_dat[1]), 32'h11);
    check("t2_b2", 32'(log_dat[2]), 32'h20);
    check("t2_b3", 32'(log_dat[3]), 32'h12);
    check("t2_g0", 32'(log_gnt[0]), 32'b001);
    check("t2_g1", 32'(log_gnt[1]), 32'b001);
    check("t2_g2", 32'(log_gnt[2]), 32'b100);
    check("t2_g3", 32'(log_gnt[3]), 32'b001);

    // 3: req1 stalls mid-message, revoked after 20 idle cycles, req2 follows
    do_reset();
    push(1, 8'h55, 1'b0);
    push(2, 8'h66, 1'b1);
    c = 0;
    while (abort_n < 1 && c < 200) begin
      @(posedge clk);
      c++;
    end
    check("t3_abort_seen", 32'(abort_n), 32'd1);
    check("t3_abort_grant", 32'(abort_gnt), 32'd0);
    check("t3_abort_delay", 32'(abort_cyc - log_cyc[0]), 32'd21);
    wait_log(2, 200);
    repeat (40) @(posedge clk);
    check("t3_count", 32'(log_n), 32'd2);
    check("t3_abort_once", 32'(abort_n), 32'd1);
    check("t3_b0", 32'(log_dat[0]), 32'h55);
    check("t3_g0", 32'(log_gnt[0]), 32'b010);
    check("t3_b1", 32'(log_dat[1]), 32'h66);
    check("t3_g1", 32'(log_gnt[1]), 32'b100);

    // 4: reset while the UART is busy with the first byte of a message
    do_reset();
    push(0, 8'h31, 1'b0);
    push(0, 8'h32, 1'b0);
    push(0, 8'h33, 1'b1);
    wait_log(1, 100);
    #2;
    reset = 1'b1;
    clear_src();
    push(1, 8'h35, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("t4_grant", 32'(grant), 32'd0);
    check("t4_ready", 32'(req_ready), 32'd0);
    check("t4_wr", 32'(uart_wr), 32'd0);
    check("t4_dat", 32'(uart_dat), 32'd0);
    check("t4_abort", 32'(abort), 32'd0);
    wait_log(2, 200);
    repeat (30) @(posedge clk);
    check("t4_count", 32'(log_n), 32'd2);
    check("t4_b1", 32'(log_dat[1]), 32'h35);
    check("t4_g1", 32'(log_gnt[1]), 32'b010);
    check("t4_wait_busy", 32'(log_cyc[1] - log_cyc[0]), 32'd11);

    // 5: one-byte message from req2, with or without the channel tag
    do_reset();
    push(2, 8'h7A, 1'b1);
`ifdef UART_ARB_TAG_EN
    wait_log(2, 200);
    repeat (30) @(posedge clk);
    check("t5_count", 32'(log_n), 32'd2);
    check("t5_tag", 32'(log_dat[0]), 32'h82);
    check("t5_b", 32'(log_dat[1]), 32'h7A);
`else
    wait_log(1, 200);
    repeat (30) @(posedge clk);
    check("t5_count", 32'(log_n), 32'd1);
    check("t5_b", 32'(log_dat[0]), 32'h7A);
    check("t5_g", 32'(log_gnt[0]), 32'b100);
`endif

    // 6: 30 back-to-back one-byte messages, grants must rotate 0,1,2
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 3; i++) push(i, 8'((i + 1) * 16 + k), 1'b1);
    end
    wait_log(30, 3000);
    repeat (30) @(posedge clk);
    check("t6_count", 32'(log_n), 32'd30);
    for (int m = 0; m < 30; m++) begin
      check("t6_byte", 32'(log_dat[m]), 32'(((m % 3) + 1) * 16 + (m / 3)));
      check("t6_grant", 32'(log_gnt[m]), 32'(1 << (m % 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
